// File: rtl/time_pkg.sv
// time_pkg: time-band codes and hour/minute limits shared by the day clock and lighting logic.
package time_pkg;
    localparam logic [3:0] TC_NONE      = 4'b0000;
    localparam logic [3:0] TC_MORNING   = 4'b0001;
    localparam logic [3:0] TC_AFTERNOON = 4'b0010;
    localparam logic [3:0] TC_EVENING   = 4'b0100;
    localparam logic [3:0] TC_NIGHT     = 4'b1000;
    localparam logic [4:0] H_MORNING    = 5'd6;
    localparam logic [4:0] H_AFTERNOON  = 5'd12;
    localparam logic [4:0] H_EVENING    = 5'd18;
    localparam logic [4:0] H_NIGHT      = 5'd22;
    localparam logic [4:0] MAX_HOUR     = 5'd23;
    localparam logic [5:0] MAX_MIN      = 6'd59;

    function automatic logic [3:0] band_of(input logic [4:0] h);
        return (h < H_MORNING)   ? TC_NIGHT :
               (h < H_AFTERNOON) ? TC_MORNING :
               (h < H_EVENING)   ? TC_AFTERNOON :
               (h < H_NIGHT)     ? TC_EVENING : TC_NIGHT;
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the clock down to a one-cycle tick every TICKS cycles while enabled.
module tick_prescaler #(
    parameter int TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICKS);
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/time_code_gen.sv
// time_code_gen: simulated day clock with range-checked time set and one-hot time-band output.
module time_code_gen
    import time_pkg::*;
#(
    parameter int TICKS_PER_MIN = 50_000_000,
    parameter int RESET_HOUR    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [3:0] tcode,
    output logic       band_chg,
    output logic       set_err
);
    logic       tick;
    logic       set_ok;
    logic [3:0] band;

    assign set_ok = set_en && (set_hour <= MAX_HOUR) && (set_min <= MAX_MIN);
    assign band   = band_of(hour);

    tick_prescaler #(.TICKS(TICKS_PER_MIN)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run),
        .clr  (set_ok),
        .tick (tick)
    );

    // A valid set overrides a coincident tick, so that tick is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour     <= 5'(RESET_HOUR);
            minute   <= '0;
            tcode    <= TC_NONE;
            band_chg <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            set_err  <= set_en && !set_ok;
            tcode    <= band;
            band_chg <= (tcode != TC_NONE) && (band != tcode);
            if (set_ok) begin
                hour   <= set_hour;
                minute <= set_min;
            end else if (tick) begin
                minute <= (minute == MAX_MIN) ? 6'd0 : minute + 6'd1;
                if (minute == MAX_MIN)
                    hour <= (hour == MAX_HOUR) ? 5'd0 : hour + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_time_code_gen.sv
// tb_time_code_gen: scoreboard bench; a minutes-of-day reference model predicts every cycle's outputs.
module tb_time_code_gen;
    localparam int T  = 4;
    localparam int RH = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [3:0] tcode;
    logic       band_chg;
    logic       set_err;

    time_code_gen #(.TICKS_PER_MIN(T), .RESET_HOUR(RH)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .set_en(set_en),
        .set_hour(set_hour), .set_min(set_min), .hour(hour), .minute(minute),
        .tcode(tcode), .band_chg(band_chg), .set_err(set_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] minute;
        logic [3:0] tcode;
        logic       band_chg;
        logic       set_err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int         mod_day = RH * 60;
    int         presc = 0;
    logic [3:0] m_tc = '0;
    logic       m_bc = 1'b0;
    logic       m_se = 1'b0;

    function automatic logic [3:0] band(input int h);
        if (h >= 6 && h < 12) return 4'b0001;
        if (h >= 12 && h < 18) return 4'b0010;
        if (h >= 18 && h < 22) return 4'b0100;
        return 4'b1000;
    endfunction

    task automatic step(input logic r_n, input logic rn, input logic se,
                        input logic [4:0] sh, input logic [5:0] sm);
        logic ok;
        @(negedge clk);
        rst_n = r_n; run = rn; set_en = se; set_hour = sh; set_min = sm;
        if (!r_n) begin
            mod_day = RH * 60; presc = 0; m_tc = '0; m_bc = 1'b0; m_se = 1'b0;
        end else begin
            ok   = se && sh <= 23 && sm <= 59;
            m_bc = (m_tc != 4'b0000) && (band(mod_day / 60) != m_tc);
            m_tc = band(mod_day / 60);
            m_se = se && !ok;
            if (ok) begin
                mod_day = int'(sh) * 60 + int'(sm);
                presc   = 0;
            end else if (rn) begin
                if (presc == T - 1) begin
                    presc   = 0;
                    mod_day = (mod_day + 1) % 1440;
                end else
                    presc++;
            end
        end
        q.push_back('{hour: 5'(mod_day / 60), minute: 6'(mod_day % 60),
                      tcode: m_tc, band_chg: m_bc, set_err: m_se});
    endtask

    task automatic idle(input int n, input logic rn);
        repeat (n) step(1'b1, rn, 1'b0, 5'd0, 6'd0);
    endtask

    task automatic set_time(input logic [4:0] sh, input logic [5:0] sm);
        step(1'b1, 1'b1, 1'b1, sh, sm);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (hour !== e.hour || minute !== e.minute || tcode !== e.tcode ||
                band_chg !== e.band_chg || set_err !== e.set_err) begin
                miscompares++;
                $display("FAIL cycle_vec%0d @%0t: got %0d:%0d tc=%b bc=%b se=%b, exp %0d:%0d tc=%b bc=%b se=%b",
                         vectors, $time, hour, minute, tcode, band_chg, set_err,
                         e.hour, e.minute, e.tcode, e.band_chg, e.set_err);
            end
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step(1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
        idle(6, 1'b1);
        set_time(5'd5, 6'd59);
        idle(6, 1'b1);
        set_time(5'd23, 6'd59);
        idle(6, 1'b1);
        idle(1, 1'b1);
        set_time(5'd24, 6'd0);
        idle(2, 1'b1);
        set_time(5'd3, 6'd60);
        idle(5, 1'b1);
        set_time(5'd10, 6'd15);
        idle(3, 1'b1);
        set_time(5'd17, 6'd30);
        idle(5, 1'b1);
        set_time(5'd8, 6'd0);
        idle(2, 1'b1);
        idle(20, 1'b0);
        idle(6, 1'b1);
        step(1'b1, 1'b0, 1'b1, 5'd21, 6'd59);
        idle(3, 1'b0);
        idle(5, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 5'd0, 6'd0);
        #1;
        vectors++;
        if (hour !== 5'(RH) || minute !== 6'd0 || tcode !== 4'b0000 || band_chg !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %0d:%0d tc=%b bc=%b, exp %0d:0 tc=0000 bc=0",
                     hour, minute, tcode, band_chg, RH);
        end
        step(1'b0, 1'b1, 1'b1, 5'd12, 6'd0);
        idle(6, 1'b1);
        repeat (500) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1,
                     5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
            else
                step(1'b1, $urandom_range(0, 4) != 0, 1'b0, 5'd0, 6'd0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/time_code_gen.md
Name: time_code_gen

Overview:
- Day-clock block that produces the 4-bit one-hot time code (tcode) consumed by the room lighting logic (active-lamp count computation).
- Counts simulated minutes and hours from the system clock through a prescaler.
- Supports a synchronous time-set with range checking.
- Encodes the current hour into the time-band code and flags band transitions.

Parameters:
- TICKS_PER_MIN, 50_000_000, clock cycles per simulated minute; legal range ≥2.
- RESET_HOUR, 0, hour value loaded on reset; legal range 0..23.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = time advances; 0 = prescaler and counters hold.
- set_en  input  1  one-cycle strobe; loads set_hour/set_min.
- set_hour  input  5  hour to load.
- set_min  input  6  minute to load.
- hour  output  5  current hour, 0..23.
- minute  output  6  current minute, 0..59.
- tcode  output  4  one-hot time code, registered.
- band_chg  output  1  one-cycle pulse when tcode changes between two nonzero codes.
- set_err  output  1  one-cycle pulse when a set request is rejected.

Behaviour:
- Reset (async, rst_n=0): prescaler=0, minute=0, hour=RESET_HOUR, tcode=4'b0000, band_chg=0, set_err=0.
- Prescaler: counts 0..TICKS_PER_MIN-1 while run=1. At terminal count it wraps to 0 and generates an internal tick.
- Tick: minute+1. When minute=59 it wraps to 0 and hour+1. When hour=23 and minute=59 it wraps to 00:00.
- Band encoding, decided table:
  - hour 6..11 -> 4'b0001 (morning)
  - hour 12..17 -> 4'b0010 (afternoon)
  - hour 18..21 -> 4'b0100 (evening, automatic lighting)
  - hour 22..23 and 0..5 -> 4'b1000 (night, user light)
- tcode timing: registered from the hour register every cycle, so it lags an hour change by exactly 1 clk. The first edge after reset release loads the band of RESET_HOUR. tcode is never 4'b0000 outside reset.
- band_chg: asserted for the same cycle in which tcode takes a new value, only if the old tcode≠0000. No pulse on the first load after reset.
- Set, valid request (set_en=1, set_hour≤23, set_min≤59): next edge loads hour/minute and clears the prescaler to 0. tcode follows one cycle later; band_chg fires if the band differs.
- Set, invalid request (set_hour>23 or set_min>59): hour/minute/prescaler unchanged, set_err=1 for one cycle. Time continues normally, including a tick in that cycle.
- Simultaneous valid set_en and tick: the set wins and the tick is discarded.
- Set is honoured regardless of run.
- run=0: prescaler and counters frozen, tcode stable.
- run toggling mid-count: the prescaler resumes from the held value, no loss.
- Reset mid-operation: immediate return to reset values; any pending set is lost.
- Width rules: all counters unsigned. Prescaler width is $clog2(TICKS_PER_MIN). No arithmetic on ports beyond compares.

Decomposition:
- Shared package time_pkg holds:
  - tcode localparams TC_NONE=4'b0000, TC_MORNING=4'b0001, TC_AFTERNOON=4'b0010, TC_EVENING=4'b0100, TC_NIGHT=4'b1000
  - band boundary hours 6, 12, 18, 22
  - MAX_HOUR=23, MAX_MIN=59
  - The same constants are used by the lighting logic.
- One sub-module, tick_prescaler: a parameterised counter with enable and synchronous clear that outputs the one-cycle tick.
- Hour/minute counters, band encoder and set logic stay in the top.

Test Plan (TICKS_PER_MIN=4):
- Reset with RESET_HOUR=0, release, run=1 -> tcode=0000 during reset, 1000 one cycle after release, band_chg=0, minute=1 after 4 clk.
- set 05:59, run=1 -> after 4 clk hour=6, minute=0. tcode=0001 one cycle later, band_chg pulses exactly 1 cycle.
- set 23:59, run=1 -> after 4 clk 00:00, tcode stays 1000, no band_chg.
- set_hour=24 or set_min=60 -> set_err 1-cycle pulse, hour/minute unchanged, counting continues.
- set_en 17:30 in the tick cycle while at 10:15 -> 17:30 loaded, no 10:16 ever visible, prescaler=0, tcode 0001->0010 with band_chg.
- run=0 for 20 clk mid-prescale, then run=1 -> minute unchanged during the hold. The next tick occurs after the remaining prescaler cycles only. rst_n pulse mid-count -> immediate reset values.
